// File: rtl/pipeline_run_checker_pkg.sv
// Shared state encoding and parameter helpers for the lab run checker.
// Imported by the checker top and its probe compare block.
package pipeline_run_checker_pkg;

  localparam logic [1:0] TRACK_PC = 2'd0;
  localparam logic [1:0] WAIT_A   = 2'd1;
  localparam logic [1:0] WAIT_B   = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Checkpoints must be ordered and reachable before the counter saturates.
  function automatic bit params_legal(
    input int pc_cycles,
    input int ckpt_a,
    input int ckpt_b,
    input int cnt_width
  );
    longint sat;
    sat = (longint'(1) << cnt_width) - 1;
    return (pc_cycles < ckpt_a) &&
           (ckpt_a < ckpt_b) &&
           (longint'(ckpt_b) < sat);
  endfunction

endpackage

// File: rtl/pipeline_run_checker_probe_compare.sv
// Masked per-probe inequality with a lowest-index priority encoder.
// Purely combinational; the top selects which expected set feeds it.
module pipeline_run_checker_probe_compare
  import pipeline_run_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PROBES = 15,
  parameter int IDX_W      = idx_width(NUM_PROBES)
) (
  input  logic [NUM_PROBES*DATA_WIDTH-1:0] probe,
  input  logic [NUM_PROBES*DATA_WIDTH-1:0] expect_val,
  input  logic [NUM_PROBES-1:0]            mask,
  output logic [NUM_PROBES-1:0]            mm,
  output logic [IDX_W-1:0]                 idx,
  output logic                             any
);

  always_comb begin
    mm = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      mm[i] = mask[i] &
        (probe[i*DATA_WIDTH +: DATA_WIDTH] !=
         expect_val[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = NUM_PROBES - 1; i >= 0; i--) begin
      if (mm[i]) idx = IDX_W'(i);
    end
  end

  assign any = |mm;

endmodule

// File: rtl/pipeline_run_checker.sv
// Run checker for the pipelined lab processor: PC trace, then two
// probe checkpoints, with sticky faults and a final pass flag.
module pipeline_run_checker
  import pipeline_run_checker_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_PROBES      = 15,
  parameter int CNT_WIDTH       = 16,
  parameter int PC_STEP         = 4,
  parameter int PC_CHECK_CYCLES = 19,
  parameter int CKPT_A          = 20,
  parameter int CKPT_B          = 225
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            pc_in,
  input  logic [NUM_PROBES*DATA_WIDTH-1:0] probe_in,
  input  logic [NUM_PROBES*DATA_WIDTH-1:0] exp_a_in,
  input  logic [NUM_PROBES*DATA_WIDTH-1:0] exp_b_in,
  input  logic [NUM_PROBES-1:0]            mask_a_in,
  input  logic [NUM_PROBES-1:0]            mask_b_in,
  output logic [CNT_WIDTH-1:0]             cycle_count,
  output logic                             fault_pc,
  output logic                             fault_a,
  output logic                             fault_b,
  output logic [NUM_PROBES-1:0]            fail_mask,
  output logic [idx_width(NUM_PROBES)-1:0] first_fail_idx,
  output logic                             done,
  output logic                             pass
);

  localparam int IDX_W = idx_width(NUM_PROBES);

  localparam logic [CNT_WIDTH-1:0] N_PC_END =
    CNT_WIDTH'(PC_CHECK_CYCLES);
  localparam logic [CNT_WIDTH-1:0] N_A = CNT_WIDTH'(CKPT_A);
  localparam logic [CNT_WIDTH-1:0] N_B = CNT_WIDTH'(CKPT_B);

  if (!params_legal(PC_CHECK_CYCLES, CKPT_A, CKPT_B, CNT_WIDTH))
  begin : g_bad_params
    $error("pipeline_run_checker: need PC_CHECK_CYCLES < CKPT_A < CKPT_B < 2**CNT_WIDTH-1");
  end

  logic [1:0]                     state;
  logic                           first_seen;
  logic [NUM_PROBES*DATA_WIDTH-1:0] exp_sel;
  logic [NUM_PROBES-1:0]          mask_sel;
  logic [NUM_PROBES-1:0]          mm;
  logic [IDX_W-1:0]               mm_idx;
  logic                           mm_any;
  logic [DATA_WIDTH-1:0]          exp_pc;
  logic                           pc_bad;
  logic                           hit_a;
  logic                           hit_b;
  logic                           sat;

  assign sat = &cycle_count;

  // Product is formed at DATA_WIDTH, so it wraps like the real PC.
  assign exp_pc = DATA_WIDTH'(cycle_count) * DATA_WIDTH'(PC_STEP);
  assign pc_bad = (pc_in !== exp_pc);

  assign hit_a = (state == WAIT_A) && (cycle_count == N_A);
  assign hit_b = (state == WAIT_B) && (cycle_count == N_B);

  assign exp_sel  = (state == WAIT_B) ? exp_b_in : exp_a_in;
  assign mask_sel = (state == WAIT_B) ? mask_b_in : mask_a_in;

  pipeline_run_checker_probe_compare #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_PROBES (NUM_PROBES),
    .IDX_W      (IDX_W)
  ) u_cmp (
    .probe      (probe_in),
    .expect_val (exp_sel),
    .mask       (mask_sel),
    .mm         (mm),
    .idx        (mm_idx),
    .any        (mm_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= TRACK_PC;
      cycle_count    <= '0;
      fault_pc       <= 1'b0;
      fault_a        <= 1'b0;
      fault_b        <= 1'b0;
      fail_mask      <= '0;
      first_fail_idx <= '0;
      first_seen     <= 1'b0;
      done           <= 1'b0;
    end else begin
      if (!sat) cycle_count <= cycle_count + 1'b1;

      unique case (state)
        TRACK_PC: begin
          if (cycle_count != '0 && pc_bad) fault_pc <= 1'b1;
          if (cycle_count == N_PC_END) state <= WAIT_A;
        end
        WAIT_A: begin
          if (hit_a) begin
            fault_a <= mm_any;
            state   <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (hit_b) begin
            fault_b <= mm_any;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: ;
        default: state <= TRACK_PC;
      endcase

      if (hit_a || hit_b) begin
        fail_mask <= fail_mask | mm;
        if (mm_any && !first_seen) begin
          first_fail_idx <= mm_idx;
          first_seen     <= 1'b1;
        end
      end
    end
  end

  assign pass = done & ~(fault_pc | fault_a | fault_b);

endmodule

// File: tb/tb_pipeline_run_checker.sv
// Directed bench: table of full runs on the default checker plus
// hand sequences for reset, mid-run reset and a narrow configuration.
module tb_pipeline_run_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [31:0]  pc_in;
  logic [479:0] probe_in;
  logic [479:0] exp_a_in;
  logic [479:0] exp_b_in;
  logic [14:0]  mask_a_in;
  logic [14:0]  mask_b_in;
  logic [15:0]  cycle_count;
  logic         fault_pc;
  logic         fault_a;
  logic         fault_b;
  logic [14:0]  fail_mask;
  logic [3:0]   first_fail_idx;
  logic         done;
  logic         pass;

  logic         p_reset;
  logic [15:0]  p_pc;
  logic [63:0]  p_probe;
  logic [63:0]  p_ea;
  logic [63:0]  p_eb;
  logic [3:0]   p_ma;
  logic [3:0]   p_mb;
  logic [15:0]  p_cnt;
  logic         p_fpc;
  logic         p_fa;
  logic         p_fb;
  logic [3:0]   p_fm;
  logic [1:0]   p_idx;
  logic         p_done;
  logic         p_pass;

  pipeline_run_checker dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .probe_in       (probe_in),
    .exp_a_in       (exp_a_in),
    .exp_b_in       (exp_b_in),
    .mask_a_in      (mask_a_in),
    .mask_b_in      (mask_b_in),
    .cycle_count    (cycle_count),
    .fault_pc       (fault_pc),
    .fault_a        (fault_a),
    .fault_b        (fault_b),
    .fail_mask      (fail_mask),
    .first_fail_idx (first_fail_idx),
    .done           (done),
    .pass           (pass)
  );

  pipeline_run_checker #(
    .DATA_WIDTH      (16),
    .NUM_PROBES      (4),
    .CNT_WIDTH       (16),
    .PC_STEP         (2),
    .PC_CHECK_CYCLES (7),
    .CKPT_A          (8),
    .CKPT_B          (12)
  ) dut_p (
    .clk            (clk),
    .reset          (p_reset),
    .pc_in          (p_pc),
    .probe_in       (p_probe),
    .exp_a_in       (p_ea),
    .exp_b_in       (p_eb),
    .mask_a_in      (p_ma),
    .mask_b_in      (p_mb),
    .cycle_count    (p_cnt),
    .fault_pc       (p_fpc),
    .fault_a        (p_fa),
    .fault_b        (p_fb),
    .fail_mask      (p_fm),
    .first_fail_idx (p_idx),
    .done           (p_done),
    .pass           (p_pass)
  );

  typedef struct {
    int          g_n;
    logic [31:0] g_val;
    logic [14:0] a_bad;
    logic [14:0] b_bad;
    logic [14:0] ma;
    logic [14:0] mb;
    logic        f_pc;
    logic        f_a;
    logic        f_b;
    logic [14:0] fm;
    logic [3:0]  idx;
    logic        ps;
  } vec_t;

  vec_t vecs[11];

  int n_cmp = 0;
  int n_bad = 0;
  int tb_n;
  int g_n;
  int pg_n;
  logic [31:0]  g_val;
  logic [479:0] pa_bus;
  logic [479:0] pb_bus;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (n=%0d)", nm, act, exp, tb_n);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    p_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    p_reset = 1'b0;
    tb_n    = 0;
  endtask

  task automatic step();
    pc_in = (tb_n == g_n) ? g_val : 32'(tb_n * 4);
    probe_in = (tb_n == 20)  ? pa_bus :
               (tb_n == 225) ? pb_bus : ~pa_bus;
    p_pc = (tb_n == pg_n) ? 16'hFFFF : 16'(tb_n * 2);
    p_probe = (tb_n == 8)  ? p_ea :
              (tb_n == 12) ? p_eb : ~p_ea;
    @(posedge clk);
    tb_n++;
    @(negedge clk);
  endtask

  task automatic setup(input vec_t v);
    for (int i = 0; i < 15; i++) begin
      pa_bus[i*32 +: 32] = exp_a_in[i*32 +: 32] - (v.a_bad[i] ? 32'd1 : 32'd0);
      pb_bus[i*32 +: 32] = exp_b_in[i*32 +: 32] ^ (v.b_bad[i] ? 32'h10 : 32'h0);
    end
    mask_a_in = v.ma;
    mask_b_in = v.mb;
    g_n       = v.g_n;
    g_val     = v.g_val;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " cycle_count"}, 64'(cycle_count), 64'(0));
    chk({tag, " fault_pc"}, 64'(fault_pc), 64'(0));
    chk({tag, " fault_a"}, 64'(fault_a), 64'(0));
    chk({tag, " fault_b"}, 64'(fault_b), 64'(0));
    chk({tag, " fail_mask"}, 64'(fail_mask), 64'(0));
    chk({tag, " first_fail_idx"}, 64'(first_fail_idx), 64'(0));
    chk({tag, " done"}, 64'(done), 64'(0));
    chk({tag, " pass"}, 64'(pass), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    p_reset = 1'b1;
    pc_in = '0;
    probe_in = '0;
    g_n = -1;
    pg_n = -1;
    g_val = '0;
    tb_n = 0;
    p_pc = '0;
    p_probe = '0;
    p_ma = 4'hF;
    p_mb = 4'hF;
    for (int i = 0; i < 15; i++) begin
      exp_a_in[i*32 +: 32] = 32'(i + 1) * 32'h80;
      exp_b_in[i*32 +: 32] = 32'hB000_0000 | 32'(i * 7);
    end
    for (int i = 0; i < 4; i++) begin
      p_ea[i*16 +: 16] = 16'h1000 + 16'(i);
      p_eb[i*16 +: 16] = 16'h2000 + 16'(i);
    end

    //           g_n  g_val         a_bad     b_bad     ma        mb        pc a  b  fm        idx ps
    vecs[0]  = '{-1, 32'h0,        15'h0000, 15'h0000, 15'h7FFF, 15'h7FFF, 0, 0, 0, 15'h0000, 0,  1};
    vecs[1]  = '{11, 32'h30,       15'h0000, 15'h0000, 15'h7FFF, 15'h7FFF, 1, 0, 0, 15'h0000, 0,  0};
    vecs[2]  = '{0,  32'hDEAD,     15'h0000, 15'h0000, 15'h7FFF, 15'h7FFF, 0, 0, 0, 15'h0000, 0,  1};
    vecs[3]  = '{19, 32'h0,        15'h0000, 15'h0000, 15'h7FFF, 15'h7FFF, 1, 0, 0, 15'h0000, 0,  0};
    vecs[4]  = '{20, 32'h0,        15'h0000, 15'h0000, 15'h7FFF, 15'h7FFF, 0, 0, 0, 15'h0000, 0,  1};
    vecs[5]  = '{-1, 32'h0,        15'h0208, 15'h0000, 15'h7FFF, 15'h7FFF, 0, 1, 0, 15'h0208, 3,  0};
    vecs[6]  = '{-1, 32'h0,        15'h0000, 15'h0020, 15'h7FFF, 15'h7FDF, 0, 0, 0, 15'h0000, 0,  1};
    vecs[7]  = '{-1, 32'h0,        15'h0000, 15'h1020, 15'h7FFF, 15'h7FFF, 0, 0, 1, 15'h1020, 5,  0};
    vecs[8]  = '{-1, 32'h0,        15'h0200, 15'h0004, 15'h7FFF, 15'h7FFF, 0, 1, 1, 15'h0204, 9,  0};
    vecs[9]  = '{-1, 32'h0,        15'h0008, 15'h0000, 15'h0000, 15'h7FFF, 0, 0, 0, 15'h0000, 0,  1};
    vecs[10] = '{-1, 32'h0,        15'h7FFF, 15'h0000, 15'h4000, 15'h7FFF, 0, 1, 0, 15'h4000, 14, 0};

    do_reset();
    chk_zero("reset");

    for (int r = 0; r < 11; r++) begin
      do_reset();
      setup(vecs[r]);
      while (tb_n < 226) begin
        step();
        if (tb_n == 20) chk("fault_a early", 64'(fault_a), 64'(0));
        if (tb_n == 21) chk("fault_a at A+1", 64'(fault_a), 64'(vecs[r].f_a));
        if (vecs[r].g_n >= 0 && tb_n == vecs[r].g_n)
          chk("fault_pc before glitch", 64'(fault_pc), 64'(0));
        if (vecs[r].g_n >= 0 && tb_n == vecs[r].g_n + 1)
          chk("fault_pc after glitch", 64'(fault_pc), 64'(vecs[r].f_pc));
        if (tb_n == 225) chk("done early", 64'(done), 64'(0));
      end
      chk("cycle_count", 64'(cycle_count), 64'(226));
      chk("done", 64'(done), 64'(1));
      chk("fault_pc", 64'(fault_pc), 64'(vecs[r].f_pc));
      chk("fault_a", 64'(fault_a), 64'(vecs[r].f_a));
      chk("fault_b", 64'(fault_b), 64'(vecs[r].f_b));
      chk("fail_mask", 64'(fail_mask), 64'(vecs[r].fm));
      chk("first_fail_idx", 64'(first_fail_idx), 64'(vecs[r].idx));
      chk("pass", 64'(pass), 64'(vecs[r].ps));
      step();
      chk("done held", 64'(done), 64'(1));
      chk("pass held", 64'(pass), 64'(vecs[r].ps));
    end

    // Reset in the middle of a run that already failed at A.
    do_reset();
    setup(vecs[5]);
    while (tb_n < 100) step();
    chk("mid fault_a", 64'(fault_a), 64'(1));
    chk("mid fail_mask", 64'(fail_mask), 64'(15'h0208));
    chk("mid idx", 64'(first_fail_idx), 64'(3));
    chk("mid cycle_count", 64'(cycle_count), 64'(100));
    do_reset();
    chk_zero("mid reset");
    setup(vecs[0]);
    while (tb_n < 226) step();
    chk("rerun pass", 64'(pass), 64'(1));
    chk("rerun fault_a", 64'(fault_a), 64'(0));

    // Narrow configuration: done at 13, PC step 2, last tracked cycle 7.
    for (int k = 0; k < 3; k++) begin
      int pgs[3];
      logic exp_pass;
      pgs[0] = -1; pgs[1] = 7; pgs[2] = 8;
      exp_pass = (k != 1);
      do_reset();
      pg_n = pgs[k];
      chk("p reset cnt", 64'(p_cnt), 64'(0));
      while (tb_n < 13) begin
        step();
        if (tb_n == 12) chk("p done early", 64'(p_done), 64'(0));
      end
      chk("p done", 64'(p_done), 64'(1));
      chk("p cnt", 64'(p_cnt), 64'(13));
      chk("p fault_pc", 64'(p_fpc), 64'(!exp_pass));
      chk("p fault_a", 64'(p_fa), 64'(0));
      chk("p fault_b", 64'(p_fb), 64'(0));
      chk("p fail_mask", 64'(p_fm), 64'(0));
      chk("p idx", 64'(p_idx), 64'(0));
      chk("p pass", 64'(p_pass), 64'(exp_pass));
    end
    pg_n = -1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
